// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: lock states and slot geometry.
package tdm_pkg;

    localparam int unsigned SLOTS  = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux1x4_if.sv
// TDM receive bus: serial beat inputs and rebuilt parallel channel outputs.
interface tdm_demux1x4_if #(
    parameter int unsigned W = 1
) ();

    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic         frame_valid;
    logic         locked;
    logic         sync_err;

    // Beat source / channel consumer side
    modport master (
        output din, din_valid, frame_sync,
        input  y0, y1, y2, y3, frame_valid, locked, sync_err
    );

    // Demultiplexer side
    modport slave (
        input  din, din_valid, frame_sync,
        output y0, y1, y2, y3, frame_valid, locked, sync_err
    );

endinterface : tdm_demux1x4_if

// File: rtl/demux1x4_en.sv
// 2-to-4 decoder: one-hot write enables for the slot addressed by an accepted beat.
module demux1x4_en
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0] i_slot,
    input  logic              i_en,
    output logic [SLOTS-1:0]  o_we_c
);

    logic w_hi;
    logic w_lo;

    assign w_hi = i_slot[1];
    assign w_lo = i_slot[0];

    // Two-level tree mirroring the transmit mux select structure
    always_comb begin
        o_we_c    = '0;
        o_we_c[0] = i_en & ~w_hi & ~w_lo;
        o_we_c[1] = i_en & ~w_hi &  w_lo;
        o_we_c[2] = i_en &  w_hi & ~w_lo;
        o_we_c[3] = i_en &  w_hi &  w_lo;
    end

endmodule : demux1x4_en

// File: rtl/tdm_demux1x4.sv
// TDM 1:4 demultiplexer: rebuilds four channels from a slot stream with frame lock tracking.
module tdm_demux1x4
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux1x4_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [SLOT_W-1:0]   w_wr_slot;
    logic                w_cap;
    logic                w_pub;
    logic                w_err;
    logic [SLOTS-1:0]    w_we;

    logic [W-1:0]        r_sh0;
    logic [W-1:0]        r_sh1;
    logic [W-1:0]        r_sh2;
    logic [W-1:0]        r_y0;
    logic [W-1:0]        r_y1;
    logic [W-1:0]        r_y2;
    logic [W-1:0]        r_y3;
    logic                r_frame_valid;
    logic                r_locked;
    logic                r_sync_err;

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, slot advance and beat classification
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_slot   = r_slot;
        w_cap       = 1'b0;
        w_pub       = 1'b0;
        w_err       = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        w_cap       = 1'b1;
                        w_wr_slot   = '0;
                        w_slot_nxt  = SLOT_W'(1);
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // Sync anywhere but slot 0 restarts the frame on this beat
                        w_err      = (r_slot != '0);
                        w_cap      = 1'b1;
                        w_wr_slot  = '0;
                        w_slot_nxt = SLOT_W'(1);
                    end else if (r_slot == '0) begin
                        w_err       = 1'b1;
                        w_slot_nxt  = '0;
                        w_state_nxt = HUNT;
                    end else if (r_slot == SLOT_W'(SLOTS - 1)) begin
                        w_pub      = 1'b1;
                        w_slot_nxt = '0;
                    end else begin
                        w_cap      = 1'b1;
                        w_slot_nxt = r_slot + SLOT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // Slot write-enable decode; enable 3 is the frame publish
    demux1x4_en u_en (
        .i_slot (w_wr_slot),
        .i_en   (w_cap | w_pub),
        .o_we_c (w_we)
    );

    // Slot counter, shadow capture, frame publish and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot        <= '0;
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_slot        <= w_slot_nxt;
            r_frame_valid <= w_pub;
            r_sync_err    <= w_err;
            r_locked      <= (w_state_nxt == LOCKED);
            if (w_we[0]) r_sh0 <= bus.din;
            if (w_we[1]) r_sh1 <= bus.din;
            if (w_we[2]) r_sh2 <= bus.din;
            if (w_we[3]) begin
                r_y0 <= r_sh0;
                r_y1 <= r_sh1;
                r_y2 <= r_sh2;
                r_y3 <= bus.din;
            end
        end
    end

    assign bus.y0          = r_y0;
    assign bus.y1          = r_y1;
    assign bus.y2          = r_y2;
    assign bus.y3          = r_y3;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_sync_err;

endmodule : tdm_demux1x4

// File: tb/tb_tdm_demux1x4.sv
// Scoreboard bench for tdm_demux1x4 with W=4 directed frames.
module tb_tdm_demux1x4;

    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    tdm_demux1x4_if #(.W(W)) bus ();

    tdm_demux1x4 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_frames[$];
    bit          exp_errs[$];
    logic [15:0] exp_hold = '0;
    bit          rst_q    = 1'b0;
    bit          seen     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=pulse required=none", name);
    endtask

    function automatic logic [15:0] fr(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        return {a, b, c, d};
    endfunction

    // One beat, then optional idle gap; starts and ends 1 time unit after a rising edge
    task automatic beat(input logic [3:0] d, input logic s, input int gap);
        bus.din        = d;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        @(posedge clk); #1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din        = '0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Sample reset level at each edge for the monitor
    initial begin
        forever begin
            @(posedge clk);
            rst_q = rst;
            seen  = 1'b1;
        end
    end

    // Monitor: pops expected frames / error pulses whenever the DUT presents them
    initial begin
        logic [15:0] y;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (seen) begin
                y = {bus.y0, bus.y1, bus.y2, bus.y3};
                if (rst_q) begin
                    exp_hold = '0;
                    check("rst_y", y, 16'h0);
                    check("rst_frame_valid", 16'(bus.frame_valid), 16'h0);
                    check("rst_sync_err", 16'(bus.sync_err), 16'h0);
                    check("rst_locked", 16'(bus.locked), 16'h0);
                end else begin
                    if (bus.frame_valid) begin
                        if (exp_frames.size() == 0) begin
                            fail_event("frame_valid_unexpected");
                        end else begin
                            e = exp_frames.pop_front();
                            check("frame_y", y, e);
                            exp_hold = e;
                        end
                    end else if (y !== exp_hold) begin
                        check("y_hold", y, exp_hold);
                    end
                    if (bus.sync_err) begin
                        if (exp_errs.size() == 0) begin
                            fail_event("sync_err_unexpected");
                        end else begin
                            void'(exp_errs.pop_front());
                            checks++;
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst            = 1'b1;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_locked", 16'(bus.locked), 16'h0);

        // Data in HUNT without sync is ignored
        beat(4'd7, 1'b0, 0);
        beat(4'd7, 1'b0, 0);
        beat(4'd7, 1'b0, 1);
        check("hunt_locked", 16'(bus.locked), 16'h0);
        check("hunt_y", {bus.y0, bus.y1, bus.y2, bus.y3}, 16'h0);

        // Back-to-back frame A..D
        beat(4'd1, 1'b1, 0);
        check("lock_rise", 16'(bus.locked), 16'h1);
        beat(4'd2, 1'b0, 0);
        beat(4'd3, 1'b0, 0);
        exp_frames.push_back(fr(4'd1, 4'd2, 4'd3, 4'd4));
        beat(4'd4, 1'b0, 0);
        check("frame1_locked", 16'(bus.locked), 16'h1);
        check("frame1_fv", 16'(bus.frame_valid), 16'h1);
        idle(1);
        check("frame1_fv_low", 16'(bus.frame_valid), 16'h0);

        // Same kind of frame with gaps between beats
        beat(4'd5, 1'b1, 3);
        beat(4'd6, 1'b0, 5);
        beat(4'd7, 1'b0, 0);
        exp_frames.push_back(fr(4'd5, 4'd6, 4'd7, 4'd8));
        beat(4'd8, 1'b0, 2);

        // Early sync in slot 2: partial frame dropped, restart on that beat
        beat(4'd9, 1'b1, 0);
        beat(4'd10, 1'b0, 0);
        exp_errs.push_back(1'b1);
        beat(4'd11, 1'b1, 0);
        check("early_sync_locked", 16'(bus.locked), 16'h1);
        beat(4'd12, 1'b0, 0);
        beat(4'd13, 1'b0, 0);
        exp_frames.push_back(fr(4'd11, 4'd12, 4'd13, 4'd14));
        beat(4'd14, 1'b0, 1);

        // Full frame, then a slot-0 beat without sync drops lock
        beat(4'd1, 1'b1, 0);
        beat(4'd3, 1'b0, 0);
        beat(4'd5, 1'b0, 0);
        exp_frames.push_back(fr(4'd1, 4'd3, 4'd5, 4'd7));
        beat(4'd7, 1'b0, 0);
        exp_errs.push_back(1'b1);
        beat(4'd15, 1'b0, 0);
        check("missing_sync_unlock", 16'(bus.locked), 16'h0);
        beat(4'd2, 1'b0, 0);
        beat(4'd4, 1'b0, 0);
        beat(4'd6, 1'b0, 1);
        check("unlocked_stays", 16'(bus.locked), 16'h0);
        check("unlocked_y_hold", {bus.y0, bus.y1, bus.y2, bus.y3}, fr(4'd1, 4'd3, 4'd5, 4'd7));

        // Reset after the slot-2 beat discards the partial frame
        beat(4'd8, 1'b1, 0);
        beat(4'd9, 1'b0, 0);
        beat(4'd10, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_locked", 16'(bus.locked), 16'h0);
        check("mid_rst_y", {bus.y0, bus.y1, bus.y2, bus.y3}, 16'h0);
        beat(4'd12, 1'b1, 0);
        beat(4'd13, 1'b0, 0);
        beat(4'd14, 1'b0, 0);
        exp_frames.push_back(fr(4'd12, 4'd13, 4'd14, 4'd15));
        beat(4'd15, 1'b0, 0);

        // Two frames at full rate
        beat(4'd1, 1'b1, 0);
        beat(4'd2, 1'b0, 0);
        beat(4'd3, 1'b0, 0);
        exp_frames.push_back(fr(4'd1, 4'd2, 4'd3, 4'd4));
        beat(4'd4, 1'b0, 0);
        beat(4'd5, 1'b1, 0);
        beat(4'd6, 1'b0, 0);
        beat(4'd7, 1'b0, 0);
        exp_frames.push_back(fr(4'd5, 4'd6, 4'd7, 4'd8));
        beat(4'd8, 1'b0, 0);
        idle(4);

        check("frames_outstanding", 16'(exp_frames.size()), 16'h0);
        check("errs_outstanding", 16'(exp_errs.size()), 16'h0);
        check("final_locked", 16'(bus.locked), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux1x4
